// File: rtl/fft_frame_sched.sv
// -----------------------------------------------------------------------------
// fft_frame_sched
//
// Frame-level controller in front of the module1 FFT stage
// (bf10 -> bf11 -> bf12 -> CBFP). Sample data bypasses this block; only the
// block-valid handshake passes through it.
//
// The block admits the 16-sample-per-cycle upstream stream into module1 in
// whole frames of BLK_PER_FRAME contiguous blocks. It limits how many frames
// are in flight through the non-stallable pipeline, and it retires frames by
// counting module1 valid_out blocks. Framing, gap and retire-timeout problems
// are reported on sticky error flags.
//
// Ports
//   clk            in   system clock, rising edge
//   rstn           in   asynchronous active-low reset
//   enable         in   allows new frames to start (sampled only in IDLE)
//   src_valid      in   upstream block valid
//   src_sof        in   upstream block is the first of a frame
//   src_ready      out  block accepted this cycle when src_valid=1
//   fft_din_valid  out  module1 din_valid (combinational, zero latency)
//   fft_dout_valid in   module1 valid_out
//   frame_done     out  one-cycle pulse on the last output block of a frame
//   inflight       out  frames accepted but not yet retired
//   busy           out  state is not IDLE or frames are in flight
//   err_sof        out  sticky framing error
//   err_gap        out  sticky mid-frame gap
//   err_timeout    out  sticky retire timeout
//   err_clr        in   synchronous clear of all sticky errors
// -----------------------------------------------------------------------------
module fft_frame_sched #(
    parameter int BLK_PER_FRAME = 32,
    parameter int MAX_INFLIGHT  = 2,
    parameter int TIMEOUT       = 64,
    parameter int CNT_W         = 6,
    localparam int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            src_valid,
    input  logic            src_sof,
    output logic            src_ready,
    output logic            fft_din_valid,
    input  logic            fft_dout_valid,
    output logic            frame_done,
    output logic [IF_W-1:0] inflight,
    output logic            busy,
    output logic            err_sof,
    output logic            err_gap,
    output logic            err_timeout,
    input  logic            err_clr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FRAME_BLKS = CNT_W'(BLK_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BLK   = CNT_W'(BLK_PER_FRAME - 1);
    localparam logic [IF_W-1:0]  MAX_IF     = IF_W'(MAX_INFLIGHT);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  in_cnt_q,   in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q,  out_cnt_d;
    logic [IF_W-1:0]   inflight_q, inflight_d;
    logic [WD_W-1:0]   wd_cnt_q,   wd_cnt_d;
    logic              err_sof_q,  err_sof_d;
    logic              err_gap_q,  err_gap_d;
    logic              err_to_q,   err_to_d;

    // Internal handshake terms. The ungated versions drive the state logic;
    // only the output pins are additionally forced low while rstn is asserted,
    // so reset never reaches a flop data input.
    logic              in_idle;
    logic              ready_int;
    logic              accept;
    logic              start;
    logic              stray;
    logic              realign;
    logic              din_int;
    logic [CNT_W-1:0]  in_cnt_nxt;
    logic              frame_end;

    // Retire / watchdog terms
    logic              has_if;
    logic              out_beat;
    logic              spurious;
    logic              retire;
    logic              wd_inc;
    logic              timeout;

    // -------------------------------------------------------------------------
    // Input side: admission and framing
    // -------------------------------------------------------------------------
    assign in_idle   = (state_q == S_IDLE);
    assign ready_int = in_idle ? (enable && (inflight_q < MAX_IF)) : 1'b1;
    assign accept    = src_valid & ready_int;

    // An IDLE beat must carry sof to open a frame; without it the beat is
    // dropped. Inside a burst every accepted beat is forwarded, and an sof
    // there restarts the block count within the frame already counted.
    assign start     = accept &  in_idle &  src_sof;
    assign stray     = accept &  in_idle & ~src_sof;
    assign realign   = accept & ~in_idle &  src_sof;
    assign din_int   = accept & (~in_idle | src_sof);

    always_comb begin
        in_cnt_nxt = in_cnt_q;
        if (start || realign) begin
            in_cnt_nxt = CNT_W'(1);
        end else if (accept && !in_idle) begin
            in_cnt_nxt = in_cnt_q + CNT_W'(1);
        end
    end

    assign frame_end = din_int && (in_cnt_nxt == FRAME_BLKS);

    // -------------------------------------------------------------------------
    // Output side: retire counting and watchdog
    // -------------------------------------------------------------------------
    assign has_if   = (inflight_q != '0);
    assign out_beat = fft_dout_valid &  has_if;
    assign spurious = fft_dout_valid & ~has_if;
    assign retire   = out_beat && (out_cnt_q == LAST_BLK);

    // The watchdog only runs while nothing is being fed in; during a burst it
    // holds, so the limit measures quiet IDLE time after the last input.
    assign wd_inc   = has_if & ~fft_dout_valid & in_idle;
    assign timeout  = wd_inc && (wd_cnt_q == WD_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_nxt;
        out_cnt_d  = out_cnt_q;
        inflight_d = inflight_q;
        wd_cnt_d   = wd_cnt_q;

        // Frame admission
        if (frame_end) begin
            state_d  = S_IDLE;
            in_cnt_d = '0;
        end else if (din_int) begin
            state_d  = S_BURST;
        end

        // Retire counter
        if (retire) begin
            out_cnt_d = '0;
        end else if (out_beat) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        // Frames in flight: a start and a retire in one cycle cancel out.
        // start is only possible below MAX_INFLIGHT and retire only above
        // zero, so the count cannot leave its range.
        case ({start, retire})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // Watchdog
        if (fft_dout_valid || !has_if) begin
            wd_cnt_d = '0;
        end else if (wd_inc) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end

        // Abort: drop every frame in flight without signalling completion.
        // A frame opened in this same cycle is still genuine and is kept.
        if (timeout) begin
            inflight_d = start ? IF_W'(1) : '0;
            out_cnt_d  = '0;
            wd_cnt_d   = '0;
        end
    end

    // Sticky flags: a same-cycle set wins over err_clr.
    always_comb begin
        err_sof_d = stray | realign | spurious | (err_sof_q & ~err_clr);
        err_gap_d = (~in_idle & ~src_valid)    | (err_gap_q & ~err_clr);
        err_to_d  = timeout                    | (err_to_q  & ~err_clr);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= '0;
            wd_cnt_q   <= '0;
            err_sof_q  <= 1'b0;
            err_gap_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            wd_cnt_q   <= wd_cnt_d;
            err_sof_q  <= err_sof_d;
            err_gap_q  <= err_gap_d;
            err_to_q   <= err_to_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The handshake pins are forced low during reset so that every output
    // reads 0 as soon as rstn falls, even with enable and src_valid high.
    assign src_ready     = ready_int & rstn;
    assign fft_din_valid = din_int & rstn;
    assign frame_done    = retire;
    assign inflight      = inflight_q;
    assign busy          = ~in_idle | has_if;
    assign err_sof       = err_sof_q;
    assign err_gap       = err_gap_q;
    assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sched
//
// Directed bench for fft_frame_sched with the default parameters
// (32 blocks per frame, 2 frames in flight, 64-cycle timeout). Inputs change
// on the falling clock edge; combinational outputs are sampled 1 ns later and
// registered outputs are read at the falling edge, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fft_frame_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic       src_valid;
    logic       src_sof;
    logic       src_ready;
    logic       fft_din_valid;
    logic       fft_dout_valid;
    logic       frame_done;
    logic [1:0] inflight;
    logic       busy;
    logic       err_sof;
    logic       err_gap;
    logic       err_timeout;
    logic       err_clr;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   din_cnt  = 0;
    int   done_cnt = 0;
    logic fd_last;

    always #5 clk = ~clk;

    fft_frame_sched #(
        .BLK_PER_FRAME(32),
        .MAX_INFLIGHT (2),
        .TIMEOUT      (64),
        .CNT_W        (6)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .src_valid     (src_valid),
        .src_sof       (src_sof),
        .src_ready     (src_ready),
        .fft_din_valid (fft_din_valid),
        .fft_dout_valid(fft_dout_valid),
        .frame_done    (frame_done),
        .inflight      (inflight),
        .busy          (busy),
        .err_sof       (err_sof),
        .err_gap       (err_gap),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle and tally the pulses of this cycle.
    task automatic settle();
        #1;
        din_cnt  += int'(fft_din_valid);
        done_cnt += int'(frame_done);
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    task automatic beats(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_sof   = (i == 0) && sof_first;
            cycle();
        end
        src_valid = 1'b0;
        src_sof   = 1'b0;
    endtask

    task automatic outs(input int n);
        for (int i = 0; i < n; i++) begin
            fft_dout_valid = 1'b1;
            settle();
            if (i == n - 1) fd_last = frame_done;
            adv();
        end
        fft_dout_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        src_valid = 1'b0;
        src_sof   = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rstn           = 1'b0;
        enable         = 1'b1;
        src_valid      = 1'b1;
        src_sof        = 1'b1;
        fft_dout_valid = 1'b0;
        err_clr        = 1'b0;
        fd_last        = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        chk("rst_src_ready", src_ready, 0);
        chk("rst_din_valid", fft_din_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_errs", {err_sof, err_gap, err_timeout}, 0);
        @(negedge clk);
        rstn      = 1'b1;
        src_valid = 1'b0;
        src_sof   = 1'b0;
        settle();
        chk("rel_src_ready", src_ready, 1);
        chk("rel_busy", busy, 0);
        adv();

        // ---------------- nominal frame ----------------
        din_cnt  = 0;
        done_cnt = 0;
        beats(1, 1'b1);
        chk("nom_inflight_1", inflight, 1);
        beats(31, 1'b0);
        chk("nom_din_count", din_cnt, 32);
        chk("nom_inflight_after_burst", inflight, 1);
        idle(10);
        chk("nom_no_early_done", done_cnt, 0);
        outs(32);
        chk("nom_done_count", done_cnt, 1);
        chk("nom_done_on_last", fd_last, 1);
        chk("nom_inflight_0", inflight, 0);
        chk("nom_errs", {err_sof, err_gap, err_timeout}, 0);

        // ---------------- credit limit ----------------
        din_cnt  = 0;
        done_cnt = 0;
        beats(32, 1'b1);
        beats(32, 1'b1);
        chk("cred_inflight_2", inflight, 2);
        chk("cred_din_two_frames", din_cnt, 64);
        src_valid = 1'b1;
        src_sof   = 1'b1;
        settle();
        chk("cred_ready_blocked", src_ready, 0);
        chk("cred_din_blocked", fft_din_valid, 0);
        adv();
        cycle();
        cycle();
        src_valid = 1'b0;
        src_sof   = 1'b0;
        chk("cred_din_still_64", din_cnt, 64);
        outs(32);
        chk("cred_done_frame1", done_cnt, 1);
        chk("cred_inflight_after_retire", inflight, 1);
        src_valid = 1'b1;
        src_sof   = 1'b1;
        settle();
        chk("cred_ready_reopened", src_ready, 1);
        chk("cred_frame3_din", fft_din_valid, 1);
        adv();
        beats(31, 1'b0);
        chk("cred_din_three_frames", din_cnt, 96);
        chk("cred_inflight_2_again", inflight, 2);
        outs(32);
        outs(32);
        chk("cred_done_all", done_cnt, 3);
        chk("cred_inflight_0", inflight, 0);
        chk("cred_errs", {err_sof, err_gap, err_timeout}, 0);

        // ---------------- missing sof ----------------
        src_valid = 1'b1;
        src_sof   = 1'b0;
        settle();
        chk("nosof_ready", src_ready, 1);
        chk("nosof_din", fft_din_valid, 0);
        adv();
        src_valid = 1'b0;
        chk("nosof_err_sof", err_sof, 1);
        chk("nosof_stays_idle", busy, 0);
        src_valid = 1'b1;
        err_clr   = 1'b1;
        cycle();
        chk("nosof_set_beats_clr", err_sof, 1);
        src_valid = 1'b0;
        cycle();
        err_clr   = 1'b0;
        chk("nosof_cleared", err_sof, 0);

        // ---------------- gap and realign ----------------
        din_cnt  = 0;
        done_cnt = 0;
        beats(10, 1'b1);
        settle();
        chk("gap_din_low", fft_din_valid, 0);
        adv();
        cycle();
        chk("gap_err_gap", err_gap, 1);
        beats(10, 1'b0);
        chk("gap_no_sof_err_yet", err_sof, 0);
        beats(1, 1'b1);
        chk("gap_realign_err_sof", err_sof, 1);
        enable = 1'b0;
        beats(30, 1'b0);
        chk("gap_still_burst", src_ready, 1);
        beats(1, 1'b0);
        chk("gap_frame_ended", src_ready, 0);
        chk("gap_inflight_1", inflight, 1);
        chk("gap_busy", busy, 1);
        chk("gap_din_count", din_cnt, 52);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("gap_errs_cleared", {err_sof, err_gap}, 0);
        enable = 1'b1;
        outs(32);
        chk("gap_done", done_cnt, 1);
        chk("gap_inflight_0", inflight, 0);

        // ---------------- timeout ----------------
        done_cnt = 0;
        beats(32, 1'b1);
        idle(63);
        chk("to_not_yet", err_timeout, 0);
        chk("to_inflight_held", inflight, 1);
        cycle();
        chk("to_err_timeout", err_timeout, 1);
        chk("to_inflight_cleared", inflight, 0);
        chk("to_busy", busy, 0);
        chk("to_no_frame_done", done_cnt, 0);
        fft_dout_valid = 1'b1;
        settle();
        chk("to_stray_out_no_done", frame_done, 0);
        adv();
        fft_dout_valid = 1'b0;
        chk("to_stray_out_err_sof", err_sof, 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("to_errs_cleared", {err_sof, err_gap, err_timeout}, 0);

        // ---------------- simultaneous start/retire, then reset ----------------
        beats(32, 1'b1);
        outs(31);
        src_valid      = 1'b1;
        src_sof        = 1'b1;
        fft_dout_valid = 1'b1;
        settle();
        chk("sim_frame_done", frame_done, 1);
        chk("sim_din_valid", fft_din_valid, 1);
        adv();
        fft_dout_valid = 1'b0;
        chk("sim_inflight_kept", inflight, 1);
        beats(5, 1'b0);
        src_valid = 1'b1;
        src_sof   = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_src_ready", src_ready, 0);
        chk("mid_rst_din_valid", fft_din_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_errs", {err_sof, err_gap, err_timeout}, 0);
        @(negedge clk);
        rstn      = 1'b1;
        src_valid = 1'b0;
        enable    = 1'b1;
        settle();
        chk("post_rst_idle_ready", src_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_inflight", inflight, 0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
